// File: rtl/dct_mac_sequencer_if.sv
// Control/handshake bundle between the DCT MAC sequencer (slave side) and the
// surrounding datapath / block controller (master side).
interface dct_mac_sequencer_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic         start_i;
    logic         start_ready_o;
    logic         mac_clr_o;
    logic         mac_ena_o;
    logic [W-1:0] tap_idx_o;
    logic [W-1:0] row_idx_o;
    logic         res_valid_o;
    logic         res_ready_i;
    logic [W-1:0] res_row_o;
    logic         busy_o;
    logic         done_o;

    modport slave (
        input  start_i,
        input  res_ready_i,
        output start_ready_o,
        output mac_clr_o,
        output mac_ena_o,
        output tap_idx_o,
        output row_idx_o,
        output res_valid_o,
        output res_row_o,
        output busy_o,
        output done_o
    );

    modport master (
        output start_i,
        output res_ready_i,
        input  start_ready_o,
        input  mac_clr_o,
        input  mac_ena_o,
        input  tap_idx_o,
        input  row_idx_o,
        input  res_valid_o,
        input  res_row_o,
        input  busy_o,
        input  done_o
    );
endinterface

// File: rtl/dct_mac_sequencer.sv
// Steps one 1-D DCT MAC through N taps x N rows, waits out the MAC pipeline and
// hands each row result over a valid/ready handshake. Optional stall counter: DCT_SEQ_PERF_EN.
module dct_mac_sequencer #(
    parameter int N       = 8,
    parameter int MAC_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
`ifdef DCT_SEQ_PERF_EN
    output logic [15:0] perf_stall_o,
`endif
    dct_mac_sequencer_if.slave bus
);
    localparam int W  = $clog2(N);
    localparam int CW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [W-1:0]  LAST_IDX  = W'(N - 1);
    localparam logic [CW-1:0] DRAIN_LD  = CW'(MAC_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t        state_reg, state_next;
    logic [W-1:0]  tap_reg,   tap_next;
    logic [W-1:0]  row_reg,   row_next;
    logic [CW-1:0] cnt_reg,   cnt_next;
    logic          done_reg,  done_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            tap_reg   <= '0;
            row_reg   <= '0;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            tap_reg   <= tap_next;
            row_reg   <= row_next;
            cnt_reg   <= cnt_next;
            done_reg  <= done_next;
        end
    end

    // With ena low every register simply keeps its value.
    always_comb begin
        state_next = state_reg;
        tap_next   = tap_reg;
        row_next   = row_reg;
        cnt_next   = cnt_reg;
        done_next  = done_reg;
        if (ena) begin
            done_next = 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.start_i) begin
                        state_next = S_ISSUE;
                        tap_next   = '0;
                        row_next   = '0;
                    end
                end
                S_ISSUE: begin
                    tap_next = tap_reg + 1'b1;
                    if (tap_reg == LAST_IDX) begin
                        state_next = S_DRAIN;
                        cnt_next   = DRAIN_LD;
                    end
                end
                S_DRAIN: begin
                    if (cnt_reg == '0) begin
                        state_next = S_HOLD;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (bus.res_ready_i) begin
                        if (row_reg == LAST_IDX) begin
                            state_next = S_IDLE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = S_ISSUE;
                            row_next   = row_reg + 1'b1;
                            tap_next   = '0;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // MAC strobes are decoded from registered state so they line up with tap_idx_o;
    // ena only masks them, it never reaches the state path combinationally.
    assign bus.mac_ena_o     = (state_reg == S_ISSUE) & ena;
    assign bus.mac_clr_o     = (state_reg == S_ISSUE) & (tap_reg == '0) & ena;
    assign bus.tap_idx_o     = tap_reg;
    assign bus.row_idx_o     = row_reg;
    assign bus.res_valid_o   = (state_reg == S_HOLD);
    assign bus.res_row_o     = row_reg;
    assign bus.busy_o        = (state_reg != S_IDLE);
    assign bus.start_ready_o = (state_reg == S_IDLE);
    assign bus.done_o        = done_reg & ena;

`ifdef DCT_SEQ_PERF_EN
    logic [15:0] perf_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_reg <= '0;
        end else if (ena) begin
            if ((state_reg == S_IDLE) && bus.start_i) begin
                perf_reg <= '0;
            end else if ((state_reg == S_HOLD) && !bus.res_ready_i && (perf_reg != 16'hFFFF)) begin
                perf_reg <= perf_reg + 16'd1;
            end
        end
    end

    assign perf_stall_o = perf_reg;
`endif
endmodule

// File: doc/dct_mac_sequencer.md
# dct_mac_sequencer

Sequencer for one 1-D DCT unit's multiply-accumulate datapath inside `fdct_zigzag.dct_mod`. It steps the MAC through N taps per coefficient row for N rows and absorbs the multiplier/accumulator pipeline latency (`mult_res` register plus accumulator). It presents each finished row result with a valid/ready handshake and applies backpressure by freezing the MAC. It replaces the free-running tap counting currently spread across the `dct_unit` instances.

## Interface
- `N`, 8: taps per row and rows per block (power of two, ≥2).
- `MAC_LAT`, 2: cycles from the last `mac_ena_o` to the final sum in the accumulator (≥1).
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high, single clock domain.
- `ena`  in  1  global clock enable. When low, all state freezes.
- `start_i`  in  1  request to process one block.
- `start_ready_o`  out  1  high in IDLE. Start is accepted on `start_i & start_ready_o & ena`.
- `mac_clr_o`  out  1  restart the accumulator with the current product. High on tap 0 only.
- `mac_ena_o`  out  1  MAC step enable.
- `tap_idx_o`  out  log2(N)  sample/coefficient column index.
- `row_idx_o`  out  log2(N)  coefficient row index.
- `res_valid_o`  out  1  accumulator holds the finished row result.
- `res_ready_i`  in  1  downstream (zigzag/quantiser) accepts the result.
- `res_row_o`  out  log2(N)  row tag accompanying `res_valid_o`.
- `busy_o`  out  1  not IDLE.
- `done_o`  out  1  one-cycle pulse after the last row transfers.

## Operation
- States:
  - IDLE
  - ISSUE: N cycles, tap 0..N-1.
  - DRAIN: MAC_LAT cycles.
  - HOLD: `res_valid_o` asserted.
- Transitions:
  - IDLE→ISSUE on an accepted start. Row=0, tap=0.
  - ISSUE: `mac_ena_o`=1. `mac_clr_o`=1 when tap=0. Tap increments each cycle. At tap=N-1 → DRAIN.
  - DRAIN: `mac_ena_o`=0. A down-counter is loaded with MAC_LAT-1. At 0 → HOLD.
  - HOLD: `res_valid_o`=1 and `res_row_o`=row. On `res_ready_i & ena`:
    - if row<N-1: row increments, tap=0, → ISSUE;
    - else → IDLE with `done_o` pulsed in the first IDLE cycle.
- Backpressure: in HOLD, `mac_ena_o`=0, so the accumulator holds its value indefinitely. `res_valid_o` never drops without a transfer.
- `ena`=0 in any state:
  - `mac_ena_o`, `mac_clr_o` and `done_o` are forced 0;
  - state, counters, `tap_idx_o`, `row_idx_o` and `res_valid_o` hold;
  - the handshake does not complete and start is not accepted.
- `start_i` while busy is ignored; nothing is queued.
- Counters wrap naturally at N (power of two). Row/tap values never exceed N-1.
- `mac_clr_o` and `mac_ena_o` are registered (state-decoded) so they align with the `tap_idx_o` that selects the coefficient ROM and sample mux in the same cycle.
- Reset: synchronous. On the next edge with `rst`=1 the block enters IDLE from any state, including mid-row or HOLD. The pending result is discarded.
- Reset values:
  - `start_ready_o`=1;
  - `busy_o`, `mac_clr_o`, `mac_ena_o`, `res_valid_o`, `done_o`=0;
  - `tap_idx_o`, `row_idx_o`, `res_row_o`=0.

## Timing
- Start accepted at edge 0 (ena=1 throughout):
  - ISSUE occupies cycles 1..N;
  - DRAIN occupies N+1..N+MAC_LAT;
  - `res_valid_o` is first high in cycle N+MAC_LAT+1.
- Per-row period with `res_ready_i` held high: N+MAC_LAT+1 cycles (11 with defaults).
- Block latency with ready high: the last transfer is in cycle N·(N+MAC_LAT+1) (88). `done_o` and `start_ready_o` go high in the next cycle (89).
- No combinational path from `res_ready_i` or `start_i` to any output.

## Configuration
- `DCT_SEQ_PERF_EN` defined:
  - adds output `perf_stall_o` [15:0], which counts cycles with `res_valid_o & ~res_ready_i & ena`;
  - the count saturates at 16'hFFFF, clears on `rst`, and clears on an accepted start.
- `DCT_SEQ_PERF_EN` undefined: the port and counter are absent. Functional behaviour is identical.

## Test plan
- Defaults, single start, `res_ready_i`=1 → per row:
  - `mac_clr_o` high once and `mac_ena_o` high 8 cycles;
  - `res_valid_o` at cycles 11, 22, …, 88 with `res_row_o`=0..7;
  - `done_o` pulse at 89.
- `res_ready_i`=0 for 5 cycles on row 3 → `res_valid_o` and `res_row_o`=3 held, `mac_ena_o`=0 throughout. With `DCT_SEQ_PERF_EN`, `perf_stall_o`=5. Block completes at cycle 93.
- `ena` low for 3 cycles mid-ISSUE at tap 4 → `tap_idx_o` stays 4 and `mac_ena_o`=0. Exactly 8 `mac_ena_o` pulses per row; `res_valid_o` is delayed to cycle 14.
- `start_i` pulsed during row 2 → ignored; only one `done_o` and 8 row transfers.
- `rst` asserted in HOLD of row 5 → next cycle: IDLE, `res_valid_o`=0, `start_ready_o`=1. A new start runs rows 0..7 normally.
- MAC_LAT=1, N=4 → per-row period 6. `res_valid_o` at cycles 6, 12, 18, 24; `done_o` at 25.
